// File: rtl/pe_xi_4_if.sv
// Signal bundle between a SAD-array PE and its driver: CB/ref pixels and per-cycle controls in,
// abs term and forwarded pixels out.
interface pe_xi_4_if #(parameter int PIXEL = 8);
  logic [PIXEL-1:0] in_curr1;
  logic [PIXEL-1:0] in_curr2;
  logic             in_curr_enable;
  logic             CB_select;
  logic [1:0]       abs_Control;
  logic [PIXEL-1:0] up_ref_adajecent_1;
  logic [PIXEL-1:0] up_ref_adajecent_8;
  logic [PIXEL-1:0] down_ref_adajecent_1;
  logic [PIXEL-1:0] down_ref_adajecent_8;
  logic             change_ref;
  logic [1:0]       ref_input_Control;
  logic [PIXEL-1:0] abs_out;
  logic [PIXEL-1:0] next_pix1;
  logic [PIXEL-1:0] next_pix2;
  logic [PIXEL-1:0] ref_pix;

  modport master (
    output in_curr1, in_curr2, in_curr_enable, CB_select, abs_Control,
           up_ref_adajecent_1, up_ref_adajecent_8,
           down_ref_adajecent_1, down_ref_adajecent_8,
           change_ref, ref_input_Control,
    input  abs_out, next_pix1, next_pix2, ref_pix
  );

  modport slave (
    input  in_curr1, in_curr2, in_curr_enable, CB_select, abs_Control,
           up_ref_adajecent_1, up_ref_adajecent_8,
           down_ref_adajecent_1, down_ref_adajecent_8,
           change_ref, ref_input_Control,
    output abs_out, next_pix1, next_pix2, ref_pix
  );
endinterface

// File: rtl/pe_xi_4.sv
// SAD-array processing element: two CB pixel registers, a vertically shiftable reference
// register, and a registered absolute-difference term.
module pe_xi_4 #(
  parameter int PIXEL = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  pe_xi_4_if.slave  pe
);

  logic [PIXEL-1:0] curr1_p0;
  logic [PIXEL-1:0] curr2_p0;
  logic [PIXEL-1:0] ref_p0;
  logic [PIXEL-1:0] abs_p1;

  logic [PIXEL-1:0] ref_src;
  logic [PIXEL-1:0] sel_pix;
  logic [PIXEL-1:0] oth_pix;
  logic [PIXEL-1:0] abs_nxt;

  function automatic logic [PIXEL-1:0] abs_diff(input logic [PIXEL-1:0] a,
                                                input logic [PIXEL-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    ref_src = pe.up_ref_adajecent_1;
    unique case (pe.ref_input_Control)
      2'b00: ref_src = pe.up_ref_adajecent_1;
      2'b01: ref_src = pe.up_ref_adajecent_8;
      2'b10: ref_src = pe.down_ref_adajecent_1;
      2'b11: ref_src = pe.down_ref_adajecent_8;
      default: ref_src = pe.up_ref_adajecent_1;
    endcase
  end

  // Abs term is formed from the registered pixels, so it lags a pixel load by one edge.
  always_comb begin
    sel_pix = pe.CB_select ? curr2_p0 : curr1_p0;
    oth_pix = pe.CB_select ? curr1_p0 : curr2_p0;
    abs_nxt = abs_p1;
    unique case (pe.abs_Control)
      2'b00: abs_nxt = abs_diff(sel_pix, ref_p0);
      2'b01: abs_nxt = '0;
      2'b10: abs_nxt = abs_p1;
      2'b11: abs_nxt = abs_diff(oth_pix, ref_p0);
      default: abs_nxt = abs_p1;
    endcase
  end

  // Stage p0: pixel registers / stage p1: abs term
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curr1_p0 <= '0;
      curr2_p0 <= '0;
      ref_p0   <= '0;
      abs_p1   <= '0;
    end else begin
      if (pe.in_curr_enable) begin
        curr1_p0 <= pe.in_curr1;
        curr2_p0 <= pe.in_curr2;
      end
      if (pe.change_ref) begin
        ref_p0 <= ref_src;
      end
      abs_p1 <= abs_nxt;
    end
  end

  assign pe.next_pix1 = curr1_p0;
  assign pe.next_pix2 = curr2_p0;
  assign pe.ref_pix   = ref_p0;
  assign pe.abs_out   = abs_p1;

endmodule

// File: tb/tb_pe_xi_4.sv
// Directed-vector bench for pe_xi_4: a table of per-edge inputs with the expected outputs
// after that edge, plus hand-written reset and load-latency sequences.
module tb_pe_xi_4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pe_xi_4_if #(.PIXEL(8)) bus ();

  pe_xi_4 #(.PIXEL(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pe    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] c1, c2;
    logic       sel;
    logic [1:0] absc;
    logic       chg;
    logic [1:0] refc;
    logic [7:0] up1, up8, dn1, dn8;
    logic [7:0] e_abs, e_n1, e_n2, e_ref;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic r, logic en, logic [7:0] c1, logic [7:0] c2, logic sel,
                              logic [1:0] absc, logic chg, logic [1:0] refc, logic [7:0] up1,
                              logic [7:0] e_abs, logic [7:0] e_n1, logic [7:0] e_n2,
                              logic [7:0] e_ref);
    vec_t v;
    v.rst_n = r;   v.en = en;     v.c1 = c1;     v.c2 = c2;
    v.sel = sel;   v.absc = absc; v.chg = chg;   v.refc = refc;
    v.up1 = up1;   v.up8 = 8'd2;  v.dn1 = 8'd3;  v.dn8 = 8'd4;
    v.e_abs = e_abs; v.e_n1 = e_n1; v.e_n2 = e_n2; v.e_ref = e_ref;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [7:0] c1, input logic [7:0] c2,
                       input logic sel, input logic [1:0] absc, input logic chg,
                       input logic [1:0] refc, input logic [7:0] up1, input logic [7:0] up8,
                       input logic [7:0] dn1, input logic [7:0] dn8);
    @(negedge clk);
    rst_n                    = r;
    bus.in_curr_enable       = en;
    bus.in_curr1             = c1;
    bus.in_curr2             = c2;
    bus.CB_select            = sel;
    bus.abs_Control          = absc;
    bus.change_ref           = chg;
    bus.ref_input_Control    = refc;
    bus.up_ref_adajecent_1   = up1;
    bus.up_ref_adajecent_8   = up8;
    bus.down_ref_adajecent_1 = dn1;
    bus.down_ref_adajecent_8 = dn8;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_abs, input logic [7:0] e_n1,
                           input logic [7:0] e_n2, input logic [7:0] e_ref);
    check({tag, ".abs_out"},   bus.abs_out,   e_abs);
    check({tag, ".next_pix1"}, bus.next_pix1, e_n1);
    check({tag, ".next_pix2"}, bus.next_pix2, e_n2);
    check({tag, ".ref_pix"},   bus.ref_pix,   e_ref);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //            rst en  c1     c2     sel absc   chg refc   up1    abs    n1     n2     ref
    tbl[0]  = mk(1, 1, 8'd15, 8'd7,  0, 2'b01, 0, 2'b00, 8'd1,   8'd0,   8'd15, 8'd7,   8'd0);
    tbl[1]  = mk(1, 0, 8'd99, 8'd88, 0, 2'b10, 0, 2'b00, 8'd1,   8'd0,   8'd15, 8'd7,   8'd0);
    tbl[2]  = mk(1, 0, 8'd99, 8'd88, 0, 2'b10, 1, 2'b00, 8'd1,   8'd0,   8'd15, 8'd7,   8'd1);
    tbl[3]  = mk(1, 0, 8'd99, 8'd88, 0, 2'b00, 1, 2'b01, 8'd1,   8'd14,  8'd15, 8'd7,   8'd2);
    tbl[4]  = mk(1, 0, 8'd99, 8'd88, 1, 2'b00, 1, 2'b10, 8'd1,   8'd5,   8'd15, 8'd7,   8'd3);
    tbl[5]  = mk(1, 0, 8'd99, 8'd88, 1, 2'b11, 1, 2'b11, 8'd1,   8'd12,  8'd15, 8'd7,   8'd4);
    tbl[6]  = mk(1, 0, 8'd99, 8'd88, 1, 2'b10, 1, 2'b00, 8'd1,   8'd12,  8'd15, 8'd7,   8'd1);
    tbl[7]  = mk(1, 0, 8'd99, 8'd88, 1, 2'b00, 0, 2'b11, 8'd1,   8'd6,   8'd15, 8'd7,   8'd1);
    tbl[8]  = mk(1, 0, 8'd99, 8'd88, 1, 2'b11, 0, 2'b11, 8'd1,   8'd14,  8'd15, 8'd7,   8'd1);
    tbl[9]  = mk(1, 0, 8'd99, 8'd88, 1, 2'b01, 0, 2'b11, 8'd1,   8'd0,   8'd15, 8'd7,   8'd1);
    tbl[10] = mk(1, 0, 8'd99, 8'd88, 1, 2'b10, 0, 2'b11, 8'd1,   8'd0,   8'd15, 8'd7,   8'd1);
    tbl[11] = mk(1, 0, 8'd99, 8'd88, 1, 2'b00, 0, 2'b11, 8'd1,   8'd6,   8'd15, 8'd7,   8'd1);
    tbl[12] = mk(1, 1, 8'd0,  8'd255,0, 2'b01, 1, 2'b00, 8'd255, 8'd0,   8'd0,  8'd255, 8'd255);
    tbl[13] = mk(1, 0, 8'd9,  8'd9,  0, 2'b00, 0, 2'b00, 8'd9,   8'd255, 8'd0,  8'd255, 8'd255);
    tbl[14] = mk(1, 0, 8'd9,  8'd9,  1, 2'b00, 0, 2'b00, 8'd9,   8'd0,   8'd0,  8'd255, 8'd255);
    tbl[15] = mk(1, 0, 8'd9,  8'd9,  1, 2'b11, 0, 2'b00, 8'd9,   8'd255, 8'd0,  8'd255, 8'd255);
    tbl[16] = mk(0, 1, 8'd50, 8'd60, 0, 2'b00, 1, 2'b00, 8'd70,  8'd0,   8'd0,  8'd0,   8'd0);
    tbl[17] = mk(1, 1, 8'd50, 8'd60, 0, 2'b00, 1, 2'b00, 8'd70,  8'd0,   8'd50, 8'd60,  8'd70);
    tbl[18] = mk(1, 0, 8'd1,  8'd2,  0, 2'b00, 0, 2'b00, 8'd3,   8'd20,  8'd50, 8'd60,  8'd70);

    // Reset held for two edges with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 1'b1,
            2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    check_all("reset", 8'd0, 8'd0, 8'd0, 8'd0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].c1, tbl[i].c2, tbl[i].sel, tbl[i].absc,
            tbl[i].chg, tbl[i].refc, tbl[i].up1, tbl[i].up8, tbl[i].dn1, tbl[i].dn8);
      check_all($sformatf("vec%0d", i), tbl[i].e_abs, tbl[i].e_n1, tbl[i].e_n2, tbl[i].e_ref);
    end

    // Simultaneous load of curr and ref with abs enabled: abs reflects pre-edge values first
    drive(1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 2'b00, 1'b1, 2'b00, 8'd255, 8'd2, 8'd3, 8'd4);
    check_all("lat_edge0", 8'd20, 8'd0, 8'd0, 8'd255);
    drive(1'b1, 1'b0, 8'd77, 8'd77, 1'b0, 2'b00, 1'b0, 2'b00, 8'd1, 8'd2, 8'd3, 8'd4);
    check_all("lat_edge1", 8'd255, 8'd0, 8'd0, 8'd255);

    // Down-8 source with CB_select swapped mid-stream
    drive(1'b1, 1'b1, 8'd100, 8'd40, 1'b1, 2'b10, 1'b1, 2'b11, 8'd1, 8'd2, 8'd3, 8'd90);
    check_all("dn8_load", 8'd255, 8'd100, 8'd40, 8'd90);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 2'b00, 1'b0, 2'b00, 8'd1, 8'd2, 8'd3, 8'd4);
    check_all("dn8_abs", 8'd50, 8'd100, 8'd40, 8'd90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
